alu_execute: RTL and testbench

Execute-stage arithmetic unit consuming the 5-bit ALU operation code produced by ALU control, plus the two register/immediate operands. Single-cycle operations resolve combinationally in the same cycle. `ALUOP_MUL` and `ALUOP_DIV` run iteratively over 32 cycles, and the unit stalls the front of the pipeline until the result is ready. The block's output feeds the EX/MEM pipeline register and branch resolution.

---
 rtl/alu_execute.sv | 183 ++++++++++++++++++
 tb/tb_alu_execute.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute.sv
// Execute-stage ALU: single-cycle ops resolve combinationally,
// MUL/DIV iterate over 32 cycles while stalling the front end.
package alu_pkg;
    localparam logic [4:0] ALUOP_ADD = 5'd0;
    localparam logic [4:0] ALUOP_SUB = 5'd1;
    localparam logic [4:0] ALUOP_AND = 5'd2;
    localparam logic [4:0] ALUOP_OR  = 5'd3;
    localparam logic [4:0] ALUOP_XOR = 5'd4;
    localparam logic [4:0] ALUOP_NOR = 5'd5;
    localparam logic [4:0] ALUOP_SLT = 5'd6;
    localparam logic [4:0] ALUOP_SLL = 5'd7;
    localparam logic [4:0] ALUOP_SRL = 5'd8;
    localparam logic [4:0] ALUOP_SRA = 5'd9;
    localparam logic [4:0] ALUOP_LUI = 5'd10;
    localparam logic [4:0] ALUOP_MOV = 5'd11;
    localparam logic [4:0] ALUOP_BEQ = 5'd12;
    localparam logic [4:0] ALUOP_BNE = 5'd13;
    localparam logic [4:0] ALUOP_MUL = 5'd14;
    localparam logic [4:0] ALUOP_DIV = 5'd15;
endpackage

module alu_execute
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [4:0]  aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic        flush,
    output logic [31:0] result,
    output logic        branch_taken,
    output logic        out_valid,
    output logic        stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        neg_q, neg_d;
    logic [31:0] res_q, res_d;

    logic        is_mul, is_div, is_iter;
    logic [31:0] abs_a, abs_b;
    logic [31:0] sc_res;
    logic        sc_taken;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] acc_step;

    assign is_mul  = (aluop == ALUOP_MUL);
    assign is_div  = (aluop == ALUOP_DIV);
    assign is_iter = is_mul | is_div;
    assign abs_a   = a[31] ? -a : a;
    assign abs_b   = b[31] ? -b : b;

    always_comb begin
        sc_res   = 32'd0;
        sc_taken = 1'b0;
        unique case (aluop)
            ALUOP_ADD: sc_res = a + b;
            ALUOP_SUB: sc_res = a - b;
            ALUOP_AND: sc_res = a & b;
            ALUOP_OR:  sc_res = a | b;
            ALUOP_XOR: sc_res = a ^ b;
            ALUOP_NOR: sc_res = ~(a | b);
            ALUOP_SLT: sc_res = {31'd0, $signed(a) < $signed(b)};
            ALUOP_SLL: sc_res = b << shamt;
            ALUOP_SRL: sc_res = b >> shamt;
            ALUOP_SRA: sc_res = $unsigned($signed(b) >>> shamt);
            ALUOP_LUI: sc_res = {b[15:0], 16'd0};
            ALUOP_MOV: sc_res = b;
            ALUOP_BEQ: sc_taken = (a == b);
            ALUOP_BNE: sc_taken = (a != b);
            default: begin
                sc_res   = 32'd0;
                sc_taken = 1'b0;
            end
        endcase
    end

    // acc holds {partial product} for MUL, {remainder, quotient} for DIV
    assign mul_sum   = {1'b0, acc_q[63:32]}
                     + {1'b0, acc_q[0] ? mag_b_q : 32'd0};
    assign div_trial = {acc_q[63:32], acc_q[31]} - {1'b0, mag_b_q};

    always_comb begin
        if (state_q == S_MUL)
            acc_step = {mul_sum, acc_q[31:1]};
        else if (!div_trial[32])
            acc_step = {div_trial[31:0], acc_q[30:0], 1'b1};
        else
            acc_step = {acc_q[62:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && is_iter) begin
                    state_d = is_mul ? S_MUL : S_DIV;
                    cnt_d   = 5'd0;
                    acc_d   = {32'd0, abs_a};
                    mag_b_d = abs_b;
                    // divide-by-zero keeps the all-ones quotient unsigned
                    neg_d   = (a[31] ^ b[31]) & ~(is_div & (b == 32'd0));
                end
            end
            S_MUL, S_DIV: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    res_d   = neg_q ? -acc_step[31:0] : acc_step[31:0];
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            mag_b_q <= 32'd0;
            neg_q   <= 1'b0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    logic idle, done;
    assign idle = (state_q == S_IDLE);
    assign done = (state_q == S_DONE);

    always_comb begin
        result       = 32'd0;
        branch_taken = 1'b0;
        out_valid    = 1'b0;
        stall        = 1'b0;
        if (reset) begin
            if (idle) begin
                result       = sc_res;
                branch_taken = sc_taken;
            end else if (done) begin
                result = res_q;
            end
            if (!flush) begin
                out_valid = (idle & in_valid & ~is_iter) | done;
                stall     = (idle & in_valid & is_iter)
                          | (state_q == S_MUL) | (state_q == S_DIV);
            end
        end
    end

endmodule

// File: tb/tb_alu_execute.sv
// Directed bench for alu_execute: single-cycle ops, branches,
// iterative MUL/DIV latency, flush and reset mid-operation.
module tb_alu_execute;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [4:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        flush;
    logic [31:0] result;
    logic        branch_taken;
    logic        out_valid;
    logic        stall;

    int errors = 0;
    int checks = 0;

    alu_execute dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .aluop        (aluop),
        .a            (a),
        .b            (b),
        .shamt        (shamt),
        .flush        (flush),
        .result       (result),
        .branch_taken (branch_taken),
        .out_valid    (out_valid),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] op,
                         input logic [31:0] xa, input logic [31:0] xb,
                         input logic [4:0] sh);
        in_valid = v;
        aluop    = op;
        a        = xa;
        b        = xb;
        shamt    = sh;
    endtask

    // Presents an iterative op in the current cycle, counts stall
    // cycles and captures outputs in the first non-stall cycle.
    task automatic run_iter(input logic [4:0] op,
                            input logic [31:0] xa, input logic [31:0] xb,
                            output int nst, output logic [31:0] r,
                            output logic ov);
        nst = 0;
        drive(1'b1, op, xa, xb, 5'd0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            nst++;
            @(posedge clk);
            #1;
        end
        r  = result;
        ov = out_valid;
        @(posedge clk);
        #1;
        drive(1'b0, ALUOP_ADD, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b1, ALUOP_ADD, 32'd1, 32'd2, 5'd0);
        @(negedge clk);
        checks++;
        if (result !== 32'd0 || out_valid !== 1'b0 || stall !== 1'b0
            || branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: res=%h ov=%b st=%b bt=%b",
                     result, out_valid, stall, branch_taken);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, ALUOP_ADD, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic test_single;
        logic [4:0]  ops[7];
        logic [31:0] va[7];
        logic [31:0] vb[7];
        logic [4:0]  vs[7];
        logic [31:0] ex[7];
        logic        ev[7];
        ops = '{ALUOP_ADD, ALUOP_SLT, ALUOP_SUB, ALUOP_LUI,
                ALUOP_SRA, ALUOP_XOR, 5'd31};
        va  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
                32'd0, 32'hF0F0F0F0, 32'd9};
        vb  = '{32'd1, 32'd1, 32'd1, 32'h00001234,
                32'h80000000, 32'hFF00FF00, 32'd9};
        vs  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0};
        ex  = '{32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h12340000,
                32'hF8000000, 32'h0FF00FF0, 32'd0};
        ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            drive(1'b1, ops[i], va[i], vb[i], vs[i]);
            @(negedge clk);
            checks++;
            if (result !== ex[i] || out_valid !== ev[i] || stall !== 1'b0
                || branch_taken !== 1'b0) begin
                errors++;
                $display("FAIL single_op%0d: res=%h ov=%b st=%b bt=%b exp=%h",
                         i, result, out_valid, stall, branch_taken, ex[i]);
            end
        end
        @(posedge clk);
        #1;
        drive(1'b0, ALUOP_ADD, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic test_branch;
        @(posedge clk);
        #1;
        drive(1'b1, ALUOP_BEQ, 32'd5, 32'd5, 5'd0);
        @(negedge clk);
        checks++;
        if (branch_taken !== 1'b1 || result !== 32'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL beq_equal: bt=%b res=%h ov=%b exp bt=1 res=0",
                     branch_taken, result, out_valid);
        end
        @(posedge clk);
        #1;
        drive(1'b1, ALUOP_BNE, 32'd5, 32'd5, 5'd0);
        @(negedge clk);
        checks++;
        if (branch_taken !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL bne_equal: bt=%b res=%h exp bt=0 res=0",
                     branch_taken, result);
        end
        @(posedge clk);
        #1;
        drive(1'b1, ALUOP_BNE, 32'd5, 32'd6, 5'd0);
        @(negedge clk);
        checks++;
        if (branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL bne_diff: bt=%b exp 1", branch_taken);
        end
        @(posedge clk);
        #1;
        drive(1'b0, ALUOP_ADD, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic test_mul;
        int          n;
        logic [31:0] r;
        logic        ov;
        @(posedge clk);
        #1;
        run_iter(ALUOP_MUL, 32'hFFFFFFFD, 32'd7, n, r, ov);
        checks++;
        if (n != 33 || r !== 32'hFFFFFFEB || ov !== 1'b1) begin
            errors++;
            $display("FAIL mul_neg: stalls=%0d res=%h ov=%b exp 33 ffffffeb 1",
                     n, r, ov);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mul_after_done: ov=%b st=%b exp 0 0",
                     out_valid, stall);
        end
    endtask

    task automatic test_div;
        logic [31:0] va[3];
        logic [31:0] vb[3];
        logic [31:0] ex[3];
        int          n;
        logic [31:0] r;
        logic        ov;
        va = '{32'hFFFFFFF9, 32'd1234, 32'h80000000};
        vb = '{32'd2, 32'd0, 32'hFFFFFFFF};
        ex = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            run_iter(ALUOP_DIV, va[i], vb[i], n, r, ov);
            checks++;
            if (n != 33 || r !== ex[i] || ov !== 1'b1) begin
                errors++;
                $display("FAIL div%0d: stalls=%0d res=%h ov=%b exp %h",
                         i, n, r, ov, ex[i]);
            end
        end
    endtask

    task automatic test_flush;
        bit seen;
        @(posedge clk);
        #1;
        drive(1'b1, ALUOP_DIV, 32'd100, 32'd7, 5'd0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: ov=%b st=%b exp 0 0",
                     out_valid, stall);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b1, ALUOP_ADD, 32'd20, 32'd22, 5'd0);
        @(negedge clk);
        checks++;
        if (result !== 32'd42 || out_valid !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_then_add: res=%h ov=%b st=%b exp 2a 1 0",
                     result, out_valid, stall);
        end
        @(posedge clk);
        #1;
        drive(1'b0, ALUOP_ADD, 32'd0, 32'd0, 5'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || stall) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_done: stray ov/stall=%b exp 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int          n;
        logic [31:0] r;
        logic        ov;
        bit          seen;
        @(posedge clk);
        #1;
        drive(1'b1, ALUOP_MUL, 32'd1000, 32'd1000, 5'd0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (result !== 32'd0 || out_valid !== 1'b0 || stall !== 1'b0
            || branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: res=%h ov=%b st=%b bt=%b exp 0",
                     result, out_valid, stall, branch_taken);
        end
        @(posedge clk);
        #1;
        drive(1'b0, ALUOP_ADD, 32'd0, 32'd0, 5'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || stall) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_discard: stray ov/stall=%b exp 0", seen);
        end
        @(posedge clk);
        #1;
        run_iter(ALUOP_MUL, 32'd6, 32'd7, n, r, ov);
        checks++;
        if (n != 33 || r !== 32'd42 || ov !== 1'b1) begin
            errors++;
            $display("FAIL mul_after_reset: stalls=%0d res=%h ov=%b exp 33 2a 1",
                     n, r, ov);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_branch;
        test_mul;
        test_div;
        test_flush;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
